bnn_layer_sequencer: RTL
========================

Name: bnn_layer_sequencer

Overview:
- Top-level controller for the binarized CNN inference pipeline: conv1 -> conv2 -> fc -> argmax.
- Accepts one 28x28 image per inference via a valid/ready handshake and sequences the three layer engines with start/done pulses.
- Runs a serial argmax over the fc scores and presents the class on a valid/ready output.
- Gates kernel/bias memory writes so weights can only change while no inference is in flight.

Parameters:
- NCLASS, 10, number of fc outputs/classes (max 16).
- SW, 17, signed width of each fc score.
- TIMEOUT, 4095, max cycles to wait for a layer done before the error state.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- image_in_valid  in  1  image present.
- image_in_ready  out  1  sequencer accepts image.
- kernel_in_valid  in  1  weight write request.
- kernel_in_ready  out  1  weight write accepted.
- kernel_layer  in  2  write target: 1=conv1, 2=conv2, 3=fc, 0=ignored.
- mem_we_conv1  out  1  write enable, conv1 kernel/offset memory.
- mem_we_conv2  out  1  write enable, conv2 kernel/offset memory.
- mem_we_fc  out  1  write enable, fc weight memory.
- conv1_start  out  1  one-cycle start pulse.
- conv1_done  in  1  conv1 finished.
- conv2_start  out  1  one-cycle start pulse.
- conv2_done  in  1  conv2 finished.
- fc_start  out  1  one-cycle start pulse.
- fc_done  in  1  fc finished.
- fc_scores  in  NCLASS*SW  packed signed scores, index i at bits [i*SW +: SW]; stable from fc_done until OUT.
- class_out_valid  out  1  class result valid.
- class_out_ready  in  1  consumer ready.
- class_out  out  4  winning class index.
- busy  out  1  state != IDLE.
- err  out  1  sticky timeout error.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; internal max score 0.
- States: IDLE, CONV1, CONV2, FC, ARGMAX, OUT, ERR.
- Write gating (combinational):
  - kernel_in_ready = (state==IDLE).
  - mem_we_convN / mem_we_fc = kernel_in_valid & kernel_in_ready & (kernel_layer == target).
  - kernel_layer 0 is accepted but drives no write enable.
- Image acceptance: image_in_ready = (state==IDLE) & !kernel_in_valid, so kernel writes win over an image in the same cycle.
- IDLE -> CONV1 on image_in_valid & image_in_ready.
- Layer sequencing:
  - On entry to CONV1, CONV2 or FC, the matching start output is high for exactly the first cycle in that state. Start pulses are registered.
  - A layer's done input is ignored during its start cycle.
  - done sampled high in a later cycle advances the state: CONV1->CONV2, CONV2->FC, FC->ARGMAX.
- Watchdog:
  - The cycle counter clears on each state entry.
  - If it reaches TIMEOUT in CONV1/CONV2/FC without done, the next state is ERR.
  - ERR: err=1, both ready outputs 0, no start pulses. Only rst_n exits ERR.
- ARGMAX:
  - Takes exactly NCLASS cycles; index k = 0..NCLASS-1, one compare per cycle.
  - k=0 loads max=score0, idx=0.
  - For k>0, replace only if score_k > max (signed, strict), so ties keep the lowest index.
  - After the last compare -> OUT, with class_out = idx, registered.
- OUT:
  - class_out_valid=1; class_out held stable until class_out_ready.
  - The valid&ready cycle -> IDLE; class_out_valid drops next cycle.
  - class_out keeps its last value in IDLE.
- Latency: with each done returned the cycle after its start, the image handshake edge to the first class_out_valid cycle is 6+NCLASS cycles (16 at default).
- Reset mid-operation: asynchronous return to IDLE; all outputs 0 immediately. Any partial inference is discarded.
- Inputs during a busy state: image_in_valid and kernel_in_valid are not consumed and do not disturb the state. Spurious done inputs in non-matching states are ignored.

Test Plan:
- Reset, then kernel_in_valid=1 with layer=1,2,3,0 over four cycles in IDLE -> mem_we_conv1, mem_we_conv2, mem_we_fc each pulse once; no enable for layer 0; image_in_ready=0 during those cycles.
- Image accepted; each done returned one cycle after its start; scores {3,-5,7,7,0,-2,1,6,-9,2}; class_out_ready=1 -> start pulses each exactly one cycle; class_out=2 (tie with index 3 keeps 2); valid 16 cycles after the accept edge.
- All scores -100 except score9=-99 -> class_out=9. All scores equal -> class_out=0.
- During CONV2 drive kernel_in_valid=1 and image_in_valid=1 -> kernel_in_ready=0, no write enables, no second image accepted; the inference completes normally.
- class_out_ready=0 for 5 cycles in OUT -> valid and class_out held steady; ready=1 -> back to IDLE next cycle, busy=0.
- TIMEOUT=20, conv2_done never asserted -> ERR after 20 cycles in CONV2, err=1, both ready outputs 0. Assert rst_n low mid-ERR -> all outputs 0 asynchronously; after release a full inference succeeds.

Source files
------------

// File: rtl/bnn_layer_sequencer.sv
// Top-level controller for the binarized CNN pipeline: sequences conv1 -> conv2 -> fc,
// runs a serial argmax over the fc scores and gates weight writes to idle periods.
module bnn_layer_sequencer #(
    parameter int NCLASS  = 10,
    parameter int SW      = 17,
    parameter int TIMEOUT = 4095
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   image_in_valid,
    output logic                   image_in_ready,
    input  logic                   kernel_in_valid,
    output logic                   kernel_in_ready,
    input  logic [1:0]             kernel_layer,
    output logic                   mem_we_conv1,
    output logic                   mem_we_conv2,
    output logic                   mem_we_fc,
    output logic                   conv1_start,
    input  logic                   conv1_done,
    output logic                   conv2_start,
    input  logic                   conv2_done,
    output logic                   fc_start,
    input  logic                   fc_done,
    input  logic [NCLASS*SW-1:0]   fc_scores,
    output logic                   class_out_valid,
    input  logic                   class_out_ready,
    output logic [3:0]             class_out,
    output logic                   busy,
    output logic                   err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV1  = 3'd1,
        S_CONV2  = 3'd2,
        S_FC     = 3'd3,
        S_ARGMAX = 3'd4,
        S_OUT    = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [CW-1:0]         cnt_r;
    logic [3:0]            k_r;
    logic [3:0]            idx_r;
    logic signed [SW-1:0]  max_r;
    logic signed [SW-1:0]  score_k_s;
    logic                  timeout_s;
    logic                  last_k_s;
    logic                  upd_s;
    logic                  conv1_start_r;
    logic                  conv2_start_r;
    logic                  fc_start_r;
    logic                  class_out_valid_r;
    logic [3:0]            class_out_r;
    logic                  busy_r;
    logic                  err_r;
    logic                  idle_s;

    // Weight-write gating and image acceptance; held low while reset is asserted
    always_comb begin
        idle_s          = rst_n & (state_r == S_IDLE);
        kernel_in_ready = idle_s;
        image_in_ready  = idle_s & ~kernel_in_valid;
        mem_we_conv1    = kernel_in_valid & idle_s & (kernel_layer == 2'd1);
        mem_we_conv2    = kernel_in_valid & idle_s & (kernel_layer == 2'd2);
        mem_we_fc       = kernel_in_valid & idle_s & (kernel_layer == 2'd3);
    end

    // Select the score currently under comparison and decide whether it wins
    always_comb begin
        score_k_s = '0;
        for (int i = 0; i < NCLASS; i++) begin
            if (k_r == i[3:0]) begin
                score_k_s = fc_scores[i*SW +: SW];
            end else begin
                score_k_s = score_k_s;
            end
        end
        timeout_s = (cnt_r == CW'(TIMEOUT - 1));
        last_k_s  = (k_r == 4'(NCLASS - 1));
        // strict compare keeps the lowest index on ties
        upd_s     = (k_r == 4'd0) | (score_k_s > max_r);
    end

    // Next-state logic; a done is ignored during the layer's own start cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (image_in_valid & image_in_ready) state_next_s = S_CONV1;
                else                                 state_next_s = S_IDLE;
            end
            S_CONV1: begin
                if (conv1_done & ~conv1_start_r) state_next_s = S_CONV2;
                else if (timeout_s)              state_next_s = S_ERR;
                else                             state_next_s = S_CONV1;
            end
            S_CONV2: begin
                if (conv2_done & ~conv2_start_r) state_next_s = S_FC;
                else if (timeout_s)              state_next_s = S_ERR;
                else                             state_next_s = S_CONV2;
            end
            S_FC: begin
                if (fc_done & ~fc_start_r) state_next_s = S_ARGMAX;
                else if (timeout_s)        state_next_s = S_ERR;
                else                       state_next_s = S_FC;
            end
            S_ARGMAX: begin
                if (last_k_s) state_next_s = S_OUT;
                else          state_next_s = S_ARGMAX;
            end
            S_OUT: begin
                if (class_out_ready) state_next_s = S_IDLE;
                else                 state_next_s = S_OUT;
            end
            S_ERR:   state_next_s = S_ERR;
            default: state_next_s = S_ERR;
        endcase
    end

    // State register, watchdog counter and argmax index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            k_r     <= 4'd0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r) begin
                cnt_r <= '0;
            end else if ((state_r == S_CONV1) || (state_r == S_CONV2) || (state_r == S_FC)) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (state_r == S_ARGMAX) k_r <= k_r + 4'd1;
            else                     k_r <= 4'd0;
        end
    end

    // Running maximum and the registered class result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_r       <= '0;
            idx_r       <= 4'd0;
            class_out_r <= 4'd0;
        end else begin
            if ((state_r == S_ARGMAX) && upd_s) begin
                max_r <= score_k_s;
                idx_r <= k_r;
            end else begin
                max_r <= max_r;
                idx_r <= idx_r;
            end
            if ((state_r == S_ARGMAX) && last_k_s) class_out_r <= upd_s ? k_r : idx_r;
            else                                   class_out_r <= class_out_r;
        end
    end

    // Registered control outputs derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv1_start_r     <= 1'b0;
            conv2_start_r     <= 1'b0;
            fc_start_r        <= 1'b0;
            class_out_valid_r <= 1'b0;
            busy_r            <= 1'b0;
            err_r             <= 1'b0;
        end else begin
            conv1_start_r     <= (state_next_s == S_CONV1) && (state_r != S_CONV1);
            conv2_start_r     <= (state_next_s == S_CONV2) && (state_r != S_CONV2);
            fc_start_r        <= (state_next_s == S_FC)    && (state_r != S_FC);
            class_out_valid_r <= (state_next_s == S_OUT);
            busy_r            <= (state_next_s != S_IDLE);
            err_r             <= (state_next_s == S_ERR);
        end
    end

    assign conv1_start     = conv1_start_r;
    assign conv2_start     = conv2_start_r;
    assign fc_start        = fc_start_r;
    assign class_out_valid = class_out_valid_r;
    assign class_out       = class_out_r;
    assign busy            = busy_r;
    assign err             = err_r;

endmodule
